// File: rtl/gate_fb_monitor.sv
// Gate-driver feedback monitor: synchronizes and debounces the 7 feedback lines and latches
// per-channel command/feedback mismatch faults. Define GATE_FB_SHUTDOWN_EN to drive shutdown_req.
module gate_fb_monitor #(
  parameter int TICK_DIV    = 50,
  parameter int FILT_CYCLES = 4,
  parameter int MISMATCH_US = 10
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [6:0] drv_cmd,
  input  logic [6:0] fb_raw,
  input  logic       fault_clr,
  output logic [6:0] fb_status,
  output logic [6:0] fault,
  output logic       fault_any,
  output logic       shutdown_req
);

  localparam int NCH = 7;

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [3:0] FILT_MAX  = 4'(FILT_CYCLES);
  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
  localparam logic [7:0] MIS_LIMIT = 8'(MISMATCH_US);

  logic [NCH-1:0] sync1_q, sync2_q, prev_q;
  logic [3:0]     fcnt_q [NCH];
  logic [3:0]     fcnt_d [NCH];
  logic [NCH-1:0] fb_status_q, fb_status_d;

  logic [7:0]     tick_cnt_q, tick_cnt_d;
  logic           tick;

  logic [1:0]     state_q [NCH];
  logic [1:0]     state_d [NCH];
  logic [7:0]     mcnt_q  [NCH];
  logic [7:0]     mcnt_d  [NCH];
  logic [NCH-1:0] fault_q, fault_d;
  logic           fault_any_q;
  logic [NCH-1:0] mismatch;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? 8'd0 : tick_cnt_q + 8'd1;
  assign mismatch   = fb_status_q ^ drv_cmd;

  // Run counter restarts at 1 on any change, so FILT_CYCLES equal samples are needed to update.
  always_comb begin
    fb_status_d = fb_status_q;
    fcnt_d      = fcnt_q;
    for (int i = 0; i < NCH; i++) begin
      if (sync2_q[i] != prev_q[i]) begin
        fcnt_d[i] = 4'd1;
      end else if (fcnt_q[i] < FILT_MAX) begin
        fcnt_d[i] = fcnt_q[i] + 4'd1;
      end
      if (fcnt_d[i] == FILT_MAX) begin
        fb_status_d[i] = sync2_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    fault_d = fault_q;
    for (int i = 0; i < NCH; i++) begin
      case (state_q[i])
        ST_OK: begin
          mcnt_d[i] = 8'd0;
          if (mismatch[i]) begin
            state_d[i] = ST_PEND;
          end
        end
        ST_PEND: begin
          if (!mismatch[i]) begin
            state_d[i] = ST_OK;
            mcnt_d[i]  = 8'd0;
          end else if (tick) begin
            if (mcnt_q[i] + 8'd1 == MIS_LIMIT) begin
              state_d[i] = ST_FAULT;
              mcnt_d[i]  = 8'd0;
              fault_d[i] = 1'b1;
            end else begin
              mcnt_d[i] = mcnt_q[i] + 8'd1;
            end
          end
        end
        ST_FAULT: begin
          mcnt_d[i]  = 8'd0;
          fault_d[i] = 1'b1;
          // A clear only releases a channel whose feedback already agrees with the command.
          if (fault_clr && !mismatch[i]) begin
            state_d[i] = ST_OK;
            fault_d[i] = 1'b0;
          end
        end
        default: begin
          state_d[i] = ST_OK;
          mcnt_d[i]  = 8'd0;
          fault_d[i] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      fb_status_q <= '0;
      tick_cnt_q  <= '0;
      fault_q     <= '0;
      fault_any_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        fcnt_q[i]  <= '0;
        state_q[i] <= ST_OK;
        mcnt_q[i]  <= '0;
      end
    end else begin
      sync1_q     <= fb_raw;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      fb_status_q <= fb_status_d;
      tick_cnt_q  <= tick_cnt_d;
      fault_q     <= fault_d;
      fault_any_q <= |fault_d;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      mcnt_q      <= mcnt_d;
    end
  end

`ifdef GATE_FB_SHUTDOWN_EN
  logic shutdown_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      shutdown_q <= 1'b0;
    end else begin
      shutdown_q <= |fault_d;
    end
  end

  assign shutdown_req = shutdown_q;
`else
  assign shutdown_req = 1'b0;
`endif

  assign fb_status = fb_status_q;
  assign fault     = fault_q;
  assign fault_any = fault_any_q;

endmodule

// File: tb/tb_gate_fb_monitor.sv
// Scoreboard bench for gate_fb_monitor: a window/arithmetic reference model queues the
// expected outputs for every cycle and a negedge monitor compares them against the DUT.
module tb_gate_fb_monitor;

  localparam int TICK_DIV    = 50;
  localparam int FILT_CYCLES = 4;
  localparam int MISMATCH_US = 10;

  logic       sysClk = 1'b0;
  logic       sysRst;
  logic [6:0] drvCmd;
  logic [6:0] fbRaw;
  logic       faultClr;
  logic [6:0] fbStatus;
  logic [6:0] fault;
  logic       faultAny;
  logic       shutdownReq;

  typedef struct {
    int         cyc;
    logic [6:0] status;
    logic [6:0] fault;
    logic       any;
    logic       sd;
  } expT;

  expT        expQ[$];
  logic [6:0] histQ[$];
  int         assertCount = 0;
  int         failCount   = 0;
  int         modelCycle;
  logic [6:0] expStatus;
  logic [6:0] expFault;
  int         onset[7];

  gate_fb_monitor #(
    .TICK_DIV   (TICK_DIV),
    .FILT_CYCLES(FILT_CYCLES),
    .MISMATCH_US(MISMATCH_US)
  ) dut (
    .sys_clk     (sysClk),
    .sys_rst     (sysRst),
    .drv_cmd     (drvCmd),
    .fb_raw      (fbRaw),
    .fault_clr   (faultClr),
    .fb_status   (fbStatus),
    .fault       (fault),
    .fault_any   (faultAny),
    .shutdown_req(shutdownReq)
  );

  always #5 sysClk = ~sysClk;

  // Number of tick cycles c in [a,b], where a tick occurs when c mod TICK_DIV == TICK_DIV-1.
  function automatic int ticksIn(input int a, input int b);
    if (b < a) return 0;
    return (b + 1) / TICK_DIV - a / TICK_DIV;
  endfunction

  task automatic modelReset();
    histQ.delete();
    for (int i = 0; i < FILT_CYCLES + 3; i++) histQ.push_back(7'h00);
    modelCycle = 0;
    expStatus  = '0;
    expFault   = '0;
    for (int i = 0; i < 7; i++) onset[i] = -1;
  endtask

  // Status follows raw delayed 3 cycles once FILT_CYCLES consecutive samples agree; a fault
  // appears once MISMATCH_US ticks have elapsed strictly after the mismatch became visible.
  task automatic modelStep(input logic [6:0] drv, input logic [6:0] raw, input logic clr);
    expT  e;
    int   sz;
    logic v;
    logic same;
    sz = histQ.size();
    for (int ch = 0; ch < 7; ch++) begin
      v    = histQ[sz-3][ch];
      same = 1'b1;
      for (int j = 1; j < FILT_CYCLES; j++) begin
        if (histQ[sz-3-j][ch] != v) same = 1'b0;
      end
      if (same) expStatus[ch] = v;
    end
    e.cyc    = modelCycle;
    e.status = expStatus;
    e.fault  = expFault;
    e.any    = |expFault;
`ifdef GATE_FB_SHUTDOWN_EN
    e.sd     = |expFault;
`else
    e.sd     = 1'b0;
`endif
    expQ.push_back(e);
    for (int ch = 0; ch < 7; ch++) begin
      if (expFault[ch]) begin
        if (clr && expStatus[ch] == drv[ch]) expFault[ch] = 1'b0;
        onset[ch] = -1;
      end else if (expStatus[ch] == drv[ch]) begin
        onset[ch] = -1;
      end else begin
        if (onset[ch] < 0) onset[ch] = modelCycle;
        if (ticksIn(onset[ch] + 1, modelCycle) >= MISMATCH_US) begin
          expFault[ch] = 1'b1;
          onset[ch]    = -1;
        end
      end
    end
    histQ.push_back(raw);
    if (histQ.size() > 32) void'(histQ.pop_front());
    modelCycle++;
  endtask

  task automatic applyStimulus(input logic [6:0] drv, input logic [6:0] raw,
                               input logic clr, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge sysClk);
      #1;
      sysRst   = 1'b0;
      drvCmd   = drv;
      fbRaw    = raw;
      faultClr = clr;
      modelStep(drv, raw, clr);
    end
  endtask

  task automatic applyReset(input int cycles);
    expT e;
    for (int k = 0; k < cycles; k++) begin
      @(posedge sysClk);
      #1;
      sysRst   = 1'b1;
      faultClr = 1'b0;
      e.cyc    = -1;
      e.status = '0;
      e.fault  = '0;
      e.any    = 1'b0;
      e.sd     = 1'b0;
      expQ.push_back(e);
    end
    modelReset();
  endtask

  task automatic checkOutput(input expT e);
    assertCount++;
    if (fbStatus !== e.status) begin
      failCount++;
      $display("[TB] FAIL fb_status cycle %0d: got %h, expected %h", e.cyc, fbStatus, e.status);
    end
    assertCount++;
    if ({fault, faultAny, shutdownReq} !== {e.fault, e.any, e.sd}) begin
      failCount++;
      $display("[TB] FAIL fault/any/shutdown cycle %0d: got %h/%b/%b, expected %h/%b/%b",
               e.cyc, fault, faultAny, shutdownReq, e.fault, e.any, e.sd);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    assertCount++;
    if (actual < lo || actual > hi) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  always @(negedge sysClk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    int lat;
    sysRst   = 1'b1;
    drvCmd   = '0;
    fbRaw    = '0;
    faultClr = 1'b0;
    applyReset(2);

    $display("[TB] idle with all-zero command and feedback");
    applyStimulus(7'h00, 7'h00, 1'b0, 2000);

    $display("[TB] ch0 feedback follows command");
    applyStimulus(7'h01, 7'h00, 1'b0, 3);
    applyStimulus(7'h01, 7'h01, 1'b0, 20);
    checkRange("ch0_status", int'(fbStatus[0]), 1, 1);
    checkRange("ch0_no_fault", int'(fault), 0, 0);

    $display("[TB] ch2 stuck low");
    lat = -1;
    for (int k = 0; k < 600 && lat < 0; k++) begin
      applyStimulus(7'h05, 7'h01, 1'b0, 1);
      if (fault[2]) lat = k;
    end
    checkRange("ch2_fault_latency", lat, 451, 501);
    checkRange("ch2_other_faults", int'(fault & 7'h7B), 0, 0);

    $display("[TB] ch5 short glitch");
    applyStimulus(7'h05, 7'h21, 1'b0, 3);
    applyStimulus(7'h05, 7'h01, 1'b0, 20);
    checkRange("ch5_glitch_status", int'(fbStatus[5]), 0, 0);

    $display("[TB] ch2 clear attempts");
    applyStimulus(7'h05, 7'h01, 1'b1, 1);
    applyStimulus(7'h05, 7'h01, 1'b0, 2);
    checkRange("ch2_clr_mismatched", int'(fault[2]), 1, 1);
    applyStimulus(7'h05, 7'h05, 1'b0, 10);
    applyStimulus(7'h05, 7'h05, 1'b1, 1);
    applyStimulus(7'h05, 7'h05, 1'b0, 1);
    checkRange("ch2_clr_matched", int'(fault[2]), 0, 0);

    $display("[TB] ch6 reset while pending");
    applyStimulus(7'h45, 7'h05, 1'b0, 260);
    applyReset(1);
    lat = -1;
    for (int k = 0; k < 600 && lat < 0; k++) begin
      applyStimulus(7'h45, 7'h05, 1'b0, 1);
      if (fault[6]) lat = k;
    end
    checkRange("ch6_fault_after_reset", lat, 451, 501);

    $display("[TB] randomized segments");
    for (int seg = 0; seg < 8; seg++) begin
      logic [6:0] drv;
      logic [6:0] stuck;
      int         len;
      if (seg == 4) applyReset(1);
      drv   = 7'($urandom);
      stuck = 7'($urandom) & 7'($urandom) & 7'($urandom);
      len   = $urandom_range(20, 700);
      for (int k = 0; k < len; k++) begin
        logic [6:0] raw;
        logic       clr;
        raw = drv ^ stuck;
        if ($urandom_range(0, 15) == 0) raw[$urandom_range(0, 6)] ^= 1'b1;
        clr = ($urandom_range(0, 39) == 0);
        applyStimulus(drv, raw, clr, 1);
      end
    end

    @(negedge sysClk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/gate_fb_monitor.md
# gate_fb_monitor

Receive-side companion to the gate drive block: samples the seven gate-driver feedback lines (5 IGBT, 2 SCR) returned from the driver boards and debounces them. Compares each filtered feedback against the commanded drive level and latches a per-channel fault when they disagree for longer than a programmable time. Sits between the driver-board feedback pins and the mainboard control/status registers, and optionally raises a global shutdown request.

## Interface
Parameters:
- TICK_DIV, 50: sys_clk cycles per timing tick (50 MHz → 1 µs); legal 2..255
- FILT_CYCLES, 4: consecutive identical synchronized samples needed to update filtered feedback; legal 1..15
- MISMATCH_US, 10: ticks of continuous mismatch before a fault latches; legal 1..255

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- drv_cmd  in  7  commanded drive levels, [4:0]=IGBT, [6:5]=SCR; synchronous to sys_clk
- fb_raw  in  7  raw feedback from driver boards, asynchronous, same bit mapping
- fault_clr  in  1  single-cycle clear request
- fb_status  out  7  filtered feedback levels
- fault  out  7  latched per-channel mismatch fault
- fault_any  out  1  OR of fault
- shutdown_req  out  1  force-all-off request (see Configuration)

## Operation
- Synchronizer: two flops per fb_raw bit.
- Filter, per channel: 4-bit run counter. If the sync sample equals the previous sync sample, the counter increments, saturating at FILT_CYCLES. Otherwise it is set to 1. When the counter reaches FILT_CYCLES, fb_status takes the sample.
- Tick generator: one counter runs 0..TICK_DIV-1 and pulses tick for one cycle at TICK_DIV-1. The period is exactly TICK_DIV cycles.
- Per-channel FSM (8-bit mismatch counter mcnt):
  - OK: fb_status==drv_cmd, mcnt=0. On mismatch → PEND.
  - PEND: mcnt increments on each tick. On match → OK with mcnt=0. On a tick where mcnt+1==MISMATCH_US → FAULT, fault bit set.
  - FAULT: fault=1, mcnt held at 0. Leaves only on fault_clr while fb_status==drv_cmd in that cycle; goes → OK. If fault_clr arrives while still mismatched, the channel stays FAULT.
- A set condition and fault_clr in the same cycle: set wins.
- Channels are independent. A fault_clr applies to all channels at once.
- Reset mid-operation: every flop returns to its reset value immediately, any FSM in any state.

## Timing
- Reset values: sync flops 0, fb_status 7'h00, fault 7'h00, fault_any 0, shutdown_req 0, tick counter 0, all FSMs OK.
- fb_raw edge to fb_status: 2 sync cycles plus FILT_CYCLES cycles. With defaults this is 6 cycles after the first stable sample.
- Mismatch onset (fb_status≠drv_cmd) to fault: between (MISMATCH_US-1)·TICK_DIV+1 and MISMATCH_US·TICK_DIV cycles, depending on tick phase. The fault is registered one cycle after the qualifying tick.
- fault_any and shutdown_req are registered and follow fault by 0 cycles, i.e. they are derived in the same clock edge as fault.
- fault_clr to fault deassertion: 1 cycle.
- A glitch shorter than FILT_CYCLES synchronized cycles never reaches fb_status.

## Configuration
- GATE_FB_SHUTDOWN_EN defined: shutdown_req=1 whenever any fault bit is 1. It is sticky with fault and clears with it.
- Not defined: shutdown_req is constant 0, and no logic is inferred for it.

## Test plan
Defaults are used in all cases, with GATE_FB_SHUTDOWN_EN defined.
- Reset, then drv_cmd=0 and fb_raw=0 for 2000 cycles → fault=0, fb_status=0, shutdown_req=0 throughout.
- drv_cmd[0]=1 with fb_raw[0] following 3 cycles later and held → fb_status[0]=1 after 6 more cycles; fault stays 0 because the mismatch lasts far less than 450 cycles.
- drv_cmd[2]=1, fb_raw[2] held 0 → fault[2]=1, fault_any=1 and shutdown_req=1 within 451..501 cycles of fb_status mismatch onset; other fault bits stay 0.
- fb_raw[5] 3-cycle glitch high with drv_cmd[5]=0 → fb_status[5] stays 0, no fault.
- Faulted ch2:
  - fault_clr while still mismatched → fault[2] stays 1.
  - Then set fb_raw[2]=1, wait 10 cycles, pulse fault_clr → fault[2]=0 the next cycle.
- ch6 in PEND at mcnt=5, assert sys_rst for 1 cycle → all outputs 0 immediately; after release, full 10-tick mismatch is needed before fault[6].
